pc_gen_btb: RTL and testbench

//   Parametrised fetch-PC generator with a direct-mapped branch target buffer (BTB)
//   and 2-bit saturating direction counters. Sits at the head of the IF stage.
//   - Issues one PC per valid/ready handshake.
//   - Takes redirects from EX.
//   - Learns taken branches from EX resolve updates, predicting them ahead of EX.

---
 rtl/pc_gen_btb.sv | 151 +++++++++++++++
 tb/tb_pc_gen_btb.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_btb.sv
// ---------------------------------------------------------------------------
// pc_gen_btb
//   Fetch-PC generator for the head of the IF stage. Issues one PC per
//   valid/ready handshake, follows EX redirects, and predicts taken branches
//   early using a direct-mapped branch target buffer with 2-bit saturating
//   direction counters that EX trains through resolve updates.
//
// Ports
//   clk           in   1     system clock
//   rst_n         in   1     asynchronous active-low reset
//   pc_o          out  XLEN  current fetch PC
//   pc_valid_o    out  1     pc_o is valid for IF
//   pc_ready_i    in   1     IF accepts pc_o this cycle
//   pred_taken_o  out  1     pc_o predicted taken (BTB hit and ctr[1])
//   pred_tgt_o    out  XLEN  predicted target for pc_o
//   redir_i       in   1     EX redirect (mispredict / trap / jump)
//   redir_pc_i    in   XLEN  redirect target
//   upd_valid_i   in   1     EX branch resolution strobe
//   upd_pc_i      in   XLEN  PC of the resolved branch
//   upd_taken_i   in   1     resolved direction
//   upd_tgt_i     in   XLEN  resolved target
// ---------------------------------------------------------------------------
module pc_gen_btb #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h8000_0000,
  parameter int              BTB_DEPTH = 16,
  parameter int              IDX_W     = $clog2(BTB_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  input  logic            pc_ready_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_tgt_o,
  input  logic            redir_i,
  input  logic [XLEN-1:0] redir_pc_i,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_tgt_i
);

  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;

  // Saturating 2-bit direction counter helpers.
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  // Fetch PC register and its valid flag.
  logic [XLEN-1:0] pc_p0;
  logic            vld_p0;

  // BTB storage, held in flops so it can be cleared by reset.
  logic [BTB_DEPTH-1:0] btb_valid;
  logic [TAG_W-1:0]     btb_tag [BTB_DEPTH];
  logic [XLEN-1:0]      btb_tgt [BTB_DEPTH];
  logic [1:0]           btb_ctr [BTB_DEPTH];

  // Lookup side (combinational on the current fetch PC).
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx = pc_p0[IDX_W+1:2];
  assign lk_tag = pc_p0[XLEN-1:IDX_W+2];
  assign lk_hit = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);

  // Gated by valid so no prediction is ever shown while the PC is not issued.
  assign pred_taken_o = vld_p0 && lk_hit && btb_ctr[lk_idx][1];
  assign pred_tgt_o   = btb_tgt[lk_idx];
  assign pc_o         = pc_p0;
  assign pc_valid_o   = vld_p0;

  // Update side (indexed by the resolved branch PC).
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[XLEN-1:IDX_W+2];
  assign up_hit = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);

  // Byte-offset bits of instruction addresses carry no information here.
  logic unused_lsbs;
  assign unused_lsbs = ^{upd_pc_i[1:0], redir_pc_i[1:0]};

  // Next-PC selection: redirect, then handshake advance, else hold.
  logic            handshake;
  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] pc_nxt;

  assign handshake = vld_p0 && pc_ready_i;
  assign pc_seq    = pc_p0 + XLEN'(4);

  always_comb begin
    pc_nxt = pc_p0;
    if (redir_i) begin
      pc_nxt = {redir_pc_i[XLEN-1:2], 2'b00};
    end else if (handshake) begin
      pc_nxt = pred_taken_o ? pred_tgt_o : pc_seq;
    end
  end

  // ---- stage p0: fetch PC register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0  <= RESET_PC;
      vld_p0 <= 1'b0;
    end else begin
      pc_p0  <= pc_nxt;
      vld_p0 <= 1'b1;
    end
  end

  // ---- BTB write port: lookups this cycle see the old contents ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btb_valid <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_tag[i] <= '0;
        btb_tgt[i] <= '0;
        btb_ctr[i] <= CTR_RESET;
      end
    end else if (upd_valid_i) begin
      if (up_hit) begin
        if (upd_taken_i) begin
          btb_ctr[up_idx] <= ctr_inc(btb_ctr[up_idx]);
          btb_tgt[up_idx] <= upd_tgt_i;
        end else begin
          btb_ctr[up_idx] <= ctr_dec(btb_ctr[up_idx]);
        end
      end else if (upd_taken_i) begin
        // Allocate or evict whatever aliases into this slot.
        btb_valid[up_idx] <= 1'b1;
        btb_tag[up_idx]   <= up_tag;
        btb_tgt[up_idx]   <= upd_tgt_i;
        btb_ctr[up_idx]   <= CTR_ALLOC;
      end
    end
  end

endmodule

// File: tb/tb_pc_gen_btb.sv
// ---------------------------------------------------------------------------
// tb_pc_gen_btb
//   Directed self-checking bench for pc_gen_btb (default parameters):
//   reset state, sequential fetch, stall, redirect priority, BTB training,
//   counter saturation, same-cycle lookup/update, aliasing, PC wrap and
//   mid-stream asynchronous reset.
// ---------------------------------------------------------------------------
module tb_pc_gen_btb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        pc_ready_i;
  logic        pred_taken_o;
  logic [31:0] pred_tgt_o;
  logic        redir_i;
  logic [31:0] redir_pc_i;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_tgt_i;

  int n_checks = 0;
  int n_errors = 0;

  pc_gen_btb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_o         (pc_o),
    .pc_valid_o   (pc_valid_o),
    .pc_ready_i   (pc_ready_i),
    .pred_taken_o (pred_taken_o),
    .pred_tgt_o   (pred_tgt_o),
    .redir_i      (redir_i),
    .redir_pc_i   (redir_pc_i),
    .upd_valid_i  (upd_valid_i),
    .upd_pc_i     (upd_pc_i),
    .upd_taken_i  (upd_taken_i),
    .upd_tgt_i    (upd_tgt_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt);
    upd_valid_i = v;
    upd_pc_i    = pc;
    upd_taken_i = tk;
    upd_tgt_i   = tgt;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redir_i    = 1'b1;
    redir_pc_i = pc;
    tick();
    redir_i    = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    pc_ready_i = 1'b1;
    redir_i    = 1'b0;
    redir_pc_i = '0;
    set_upd(1'b0, '0, 1'b0, '0);

    // Reset state
    #12;
    check("rst_pc", pc_o, 32'h8000_0000);
    check("rst_valid", {31'd0, pc_valid_o}, 32'd0);
    check("rst_pred", {31'd0, pred_taken_o}, 32'd0);

    // Release away from the edge: cycle 0 still invalid
    rst_n = 1'b1;
    check("rel_valid", {31'd0, pc_valid_o}, 32'd0);
    check("rel_pc", pc_o, 32'h8000_0000);

    // Sequential fetch
    tick();
    check("seq0_valid", {31'd0, pc_valid_o}, 32'd1);
    check("seq0_pc", pc_o, 32'h8000_0000);
    tick(); check("seq1_pc", pc_o, 32'h8000_0004);
    tick(); check("seq2_pc", pc_o, 32'h8000_0008);
    tick(); check("seq3_pc", pc_o, 32'h8000_000C);
    tick(); check("seq4_pc", pc_o, 32'h8000_0010);

    // Stall three cycles
    pc_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc_o, 32'h8000_0010);
    end
    pc_ready_i = 1'b1;
    tick(); check("resume_pc", pc_o, 32'h8000_0014);

    // Redirect with simultaneous handshake, unaligned target
    redirect(32'h8000_0102);
    check("redir_pc", pc_o, 32'h8000_0100);

    // Train a taken branch at 0x20 while redirecting to it
    pc_ready_i = 1'b0;
    set_upd(1'b1, 32'h8000_0020, 1'b1, 32'h8000_0080);
    redirect(32'h8000_0020);
    set_upd(1'b0, '0, 1'b0, '0);
    check("train_pc", pc_o, 32'h8000_0020);
    check("train_pred", {31'd0, pred_taken_o}, 32'd1);
    check("train_tgt", pred_tgt_o, 32'h8000_0080);
    pc_ready_i = 1'b1;
    tick(); check("follow_tgt", pc_o, 32'h8000_0080);

    // Two not-taken updates: 10 -> 01 -> 00
    pc_ready_i = 1'b0;
    set_upd(1'b1, 32'h8000_0020, 1'b0, 32'h0);
    redirect(32'h8000_0020);
    check("nt1_pred", {31'd0, pred_taken_o}, 32'd0);
    tick();
    set_upd(1'b0, '0, 1'b0, '0);
    check("nt2_pred", {31'd0, pred_taken_o}, 32'd0);
    check("nt2_pc", pc_o, 32'h8000_0020);
    pc_ready_i = 1'b1;
    tick(); check("nt_fallthru", pc_o, 32'h8000_0024);

    // Lower saturation: 00 -nt-> 00 -t-> 01 -t-> 10
    pc_ready_i = 1'b0;
    redirect(32'h8000_0020);
    set_upd(1'b1, 32'h8000_0020, 1'b0, 32'h0);
    tick();
    set_upd(1'b1, 32'h8000_0020, 1'b1, 32'h8000_0088);
    tick();
    check("sat_lo_01", {31'd0, pred_taken_o}, 32'd0);
    tick();
    set_upd(1'b0, '0, 1'b0, '0);
    check("sat_lo_10", {31'd0, pred_taken_o}, 32'd1);
    check("sat_lo_tgt", pred_tgt_o, 32'h8000_0088);

    // Same-cycle lookup and update: old contents seen first
    redirect(32'h8000_0024);
    check("same_pre0", {31'd0, pred_taken_o}, 32'd0);
    set_upd(1'b1, 32'h8000_0024, 1'b1, 32'h8000_0200);
    #1;
    check("same_pre1", {31'd0, pred_taken_o}, 32'd0);
    tick();
    set_upd(1'b0, '0, 1'b0, '0);
    check("same_post", {31'd0, pred_taken_o}, 32'd1);
    check("same_tgt", pred_tgt_o, 32'h8000_0200);
    check("same_pc", pc_o, 32'h8000_0024);

    // Upper saturation: 10 -t-> 11 -t-> 11 -nt-> 10 -nt-> 01
    set_upd(1'b1, 32'h8000_0024, 1'b1, 32'h8000_0200);
    tick(); tick();
    set_upd(1'b1, 32'h8000_0024, 1'b0, 32'h0);
    tick();
    check("sat_hi_10", {31'd0, pred_taken_o}, 32'd1);
    tick();
    set_upd(1'b0, '0, 1'b0, '0);
    check("sat_hi_01", {31'd0, pred_taken_o}, 32'd0);

    // Aliasing: 0x40 evicts 0x00 (same index)
    set_upd(1'b1, 32'h8000_0000, 1'b1, 32'h8000_0300);
    tick();
    set_upd(1'b1, 32'h8000_0040, 1'b1, 32'h8000_0400);
    tick();
    set_upd(1'b0, '0, 1'b0, '0);
    redirect(32'h8000_0000);
    check("alias_miss", {31'd0, pred_taken_o}, 32'd0);
    redirect(32'h8000_0040);
    check("alias_hit", {31'd0, pred_taken_o}, 32'd1);
    check("alias_tgt", pred_tgt_o, 32'h8000_0400);

    // PC wrap
    redirect(32'hFFFF_FFFC);
    check("wrap_pre", pc_o, 32'hFFFF_FFFC);
    check("wrap_pred", {31'd0, pred_taken_o}, 32'd0);
    pc_ready_i = 1'b1;
    tick(); check("wrap_pc", pc_o, 32'h0000_0000);
    tick(); check("wrap_next", pc_o, 32'h0000_0004);

    // Mid-stream async reset with an update in flight
    set_upd(1'b1, 32'h8000_0030, 1'b1, 32'h8000_0900);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pc", pc_o, 32'h8000_0000);
    check("mid_rst_valid", {31'd0, pc_valid_o}, 32'd0);
    check("mid_rst_pred", {31'd0, pred_taken_o}, 32'd0);
    tick();
    check("mid_rst_hold", pc_o, 32'h8000_0000);
    set_upd(1'b0, '0, 1'b0, '0);
    rst_n = 1'b1;

    // BTB cleared, in-flight update lost
    redirect(32'h8000_0040);
    check("clr_valid", {31'd0, pc_valid_o}, 32'd1);
    check("clr_pc", pc_o, 32'h8000_0040);
    check("clr_0040", {31'd0, pred_taken_o}, 32'd0);
    redirect(32'h8000_0024);
    check("clr_0024", {31'd0, pred_taken_o}, 32'd0);
    redirect(32'h8000_0030);
    check("clr_inflight", {31'd0, pred_taken_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
